// File: rtl/neuron_layer_seq.sv
// neuron_layer_seq
// Time-multiplexed fully-connected layer: NO neurons over NI fixed-point inputs,
// computed on P physical MAC lanes, G = ceil(NO/P) groups per transaction.
// Each group takes NI MAC cycles plus one write-back cycle.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   input handshake; only 'inputs' is registered, weights
//                         and bias must be held stable until out_valid
//   inputs   [NI]         activations, QM.QN signed
//   weights  [NO][NI]     weight matrix, row j feeds neuron j, WM.WN signed
//   bias     [NO]         per-neuron bias, QM.QN signed
//   out_valid / out_ready output handshake
//   result   [NO]         saturated layer output, QM.QN signed
//   sat_flag              some neuron saturated during this transaction
//
// Optional feature macro: NEURON_RELU_EN (ReLU on the stored value).
//
// state | meaning
// IDLE  | waiting for in_valid, in_ready=1
// MAC   | lanes accumulate w*x for input index i
// WB    | lanes round/saturate and store their neuron results
// DONE  | out_valid=1, holding results until out_ready
module neuron_layer_seq #(
  parameter int NI = 2,
  parameter int NO = 2,
  parameter int P  = 1,
  parameter int QM = 3,
  parameter int QN = 5,
  parameter int WM = 6,
  parameter int WN = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [QM+QN-1:0]   inputs  [NI],
  input  logic signed [WM+WN-1:0]   weights [NO][NI],
  input  logic signed [QM+QN-1:0]   bias    [NO],
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [QM+QN-1:0]   result  [NO],
  output logic                      sat_flag
);

  localparam int D  = QM + QN;
  localparam int WB_W = WM + WN;
  localparam int PW = D + WB_W;
  localparam int AW = PW + $clog2(NI) + 1;
  localparam int G  = (NO + P - 1) / P;
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam int IW = (NI > 1) ? $clog2(NI) : 1;
  localparam int NW = (NO > 1) ? $clog2(NO) : 1;

  localparam logic signed [AW-1:0] MAXV = {{(AW-D+1){1'b0}}, {(D-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-D+1){1'b1}}, {(D-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, WB, DONE} state_t;

  state_t state, state_n;

  logic [GW-1:0]          g_q;
  logic [IW-1:0]          i_q;
  logic signed [D-1:0]    x_reg   [NI];
  logic signed [AW-1:0]   acc     [P];

  logic signed [AW-1:0]   acc_n    [P];
  logic signed [D-1:0]    lane_res [P];
  logic                   lane_sat [P];
  logic                   lane_on  [P];
  logic [NW-1:0]          lane_idx [P];
  logic                   any_sat;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) state_n = MAC;
      end
      MAC: begin
        if (i_q == IW'(NI - 1)) state_n = WB;
      end
      WB: begin
        if (g_q == GW'(G - 1)) state_n = DONE;
        else                   state_n = MAC;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Per-lane datapath. Lanes past the last neuron (when P does not divide NO)
  // read a clamped row so indexing stays in range, and are masked by lane_on.
  always_comb begin
    any_sat = 1'b0;
    for (int l = 0; l < P; l++) begin
      int                      idx;
      logic signed [WB_W-1:0]  w;
      logic signed [PW-1:0]    prod;
      logic signed [AW-1:0]    sum;
      logic signed [AW-1:0]    shv;
      logic signed [D-1:0]     val;
      logic                    sat;

      idx         = int'(g_q) * P + l;
      lane_on[l]  = (idx < NO);
      lane_idx[l] = NW'((idx < NO) ? idx : NO - 1);

      w      = lane_on[l] ? weights[lane_idx[l]][i_q] : '0;
      prod   = $signed({{(PW-WB_W){w[WB_W-1]}}, w}) *
               $signed({{(PW-D){x_reg[i_q][D-1]}}, x_reg[i_q]});
      acc_n[l] = acc[l] + $signed({{(AW-PW){prod[PW-1]}}, prod});

      // Bias aligned to the product's QN+WN fraction bits, then the sum is
      // dropped back to QN fraction bits with floor rounding.
      sum = acc[l] + ($signed({{(AW-D){bias[lane_idx[l]][D-1]}}, bias[lane_idx[l]]}) <<< WN);
      shv = sum >>> WN;
      sat = 1'b0;
      if (shv > MAXV) begin
        val = MAXV[D-1:0];
        sat = 1'b1;
      end else if (shv < MINV) begin
        val = MINV[D-1:0];
        sat = 1'b1;
      end else begin
        val = shv[D-1:0];
      end
`ifdef NEURON_RELU_EN
      if (val < 0) val = '0;
`endif
      lane_res[l] = val;
      lane_sat[l] = sat && lane_on[l];
      any_sat     = any_sat | lane_sat[l];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      g_q      <= '0;
      i_q      <= '0;
      sat_flag <= 1'b0;
      for (int k = 0; k < NI; k++) x_reg[k]  <= '0;
      for (int l = 0; l < P; l++)  acc[l]    <= '0;
      for (int n = 0; n < NO; n++) result[n] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            g_q      <= '0;
            i_q      <= '0;
            sat_flag <= 1'b0;
            for (int k = 0; k < NI; k++) x_reg[k] <= inputs[k];
            for (int l = 0; l < P; l++)  acc[l]   <= '0;
          end
        end
        MAC: begin
          for (int l = 0; l < P; l++) acc[l] <= acc_n[l];
          i_q <= (i_q == IW'(NI - 1)) ? '0 : i_q + 1'b1;
        end
        WB: begin
          for (int l = 0; l < P; l++)
            if (lane_on[l]) result[lane_idx[l]] <= lane_res[l];
          sat_flag <= sat_flag | any_sat;
          if (g_q != GW'(G - 1)) begin
            g_q <= g_q + 1'b1;
            i_q <= '0;
            for (int l = 0; l < P; l++) acc[l] <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_layer_seq.sv
module tb_neuron_layer_seq;

`ifdef NEURON_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic clk;
  logic rst;
  logic signed [7:0]  xin [2];
  logic signed [15:0] wa  [2][2];
  logic signed [7:0]  ba  [2];
  logic signed [15:0] wc  [3][2];
  logic signed [7:0]  bc  [3];

  logic iv_a, ir_a, ov_a, or_a, sat_a;
  logic iv_b, ir_b, ov_b, or_b, sat_b;
  logic iv_c, ir_c, ov_c, or_c, sat_c;
  logic signed [7:0] res_a [2];
  logic signed [7:0] res_b [2];
  logic signed [7:0] res_c [3];

  int vectors = 0;
  int miscompares = 0;

  neuron_layer_seq #(.NI(2), .NO(2), .P(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(ir_a), .inputs(xin),
    .weights(wa), .bias(ba), .out_valid(ov_a), .out_ready(or_a),
    .result(res_a), .sat_flag(sat_a));

  neuron_layer_seq #(.NI(2), .NO(2), .P(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(ir_b), .inputs(xin),
    .weights(wa), .bias(ba), .out_valid(ov_b), .out_ready(or_b),
    .result(res_b), .sat_flag(sat_b));

  neuron_layer_seq #(.NI(2), .NO(3), .P(2)) dut_c (
    .clk(clk), .rst(rst), .in_valid(iv_c), .in_ready(ir_c), .inputs(xin),
    .weights(wc), .bias(bc), .out_valid(ov_c), .out_ready(or_c),
    .result(res_c), .sat_flag(sat_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_basic;
    xin[0] = 8'sd32;     xin[1] = 8'sd16;
    wa[0][0] = 16'sd1024; wa[0][1] = 16'sd1024;
    wa[1][0] = 16'sd2048; wa[1][1] = -16'sd1024;
    ba[0] = 8'sd8;       ba[1] = 8'sd0;
  endtask

  task automatic run_a(output int lat);
    iv_a = 1'b1;
    tick();
    iv_a = 1'b0;
    lat = 0;
    while (!ov_a && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_b(output int lat);
    iv_b = 1'b1;
    tick();
    iv_b = 1'b0;
    lat = 0;
    while (!ov_b && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_c(output int lat);
    iv_c = 1'b1;
    tick();
    iv_c = 1'b0;
    lat = 0;
    while (!ov_c && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    iv_a = 0; iv_b = 0; iv_c = 0;
    or_a = 1; or_b = 1; or_c = 1;
    set_basic();
    for (int k = 0; k < 3; k++) begin
      wc[k][0] = 16'sd0; wc[k][1] = 16'sd0; bc[k] = 8'sd0;
    end
    tick(); tick(); tick();
    vectors++; if (ir_a !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready_low: got %b want 0", ir_a); end
    vectors++; if (ov_a !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", ov_a); end
    vectors++; if (res_a[0] !== 8'sd0 || res_a[1] !== 8'sd0) begin miscompares++; $display("FAIL reset_result: got %0d,%0d want 0,0", res_a[0], res_a[1]); end
    vectors++; if (sat_a !== 1'b0) begin miscompares++; $display("FAIL reset_sat: got %b want 0", sat_a); end
    vectors++; if (res_c[2] !== 8'sd0) begin miscompares++; $display("FAIL reset_result_c2: got %0d want 0", res_c[2]); end
    rst = 1'b0;
    #1;
    vectors++; if (ir_a !== 1'b1 || ir_b !== 1'b1 || ir_c !== 1'b1) begin miscompares++; $display("FAIL reset_release_ready: got %b%b%b want 111", ir_a, ir_b, ir_c); end
  endtask

  task automatic test_basic;
    int lat;
    set_basic();
    run_a(lat);
    vectors++; if (lat !== 6) begin miscompares++; $display("FAIL basic_latency: got %0d want 6", lat); end
    vectors++; if (res_a[0] !== 8'sd56) begin miscompares++; $display("FAIL basic_r0: got %0d want 56", res_a[0]); end
    vectors++; if (res_a[1] !== 8'sd48) begin miscompares++; $display("FAIL basic_r1: got %0d want 48", res_a[1]); end
    vectors++; if (sat_a !== 1'b0) begin miscompares++; $display("FAIL basic_sat: got %b want 0", sat_a); end
    tick();
    vectors++; if (ov_a !== 1'b0 || ir_a !== 1'b1) begin miscompares++; $display("FAIL basic_handoff: got ov=%b ir=%b want ov=0 ir=1", ov_a, ir_a); end
  endtask

  task automatic test_lane_scaling;
    int lat;
    set_basic();
    run_b(lat);
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL lanes_p2_latency: got %0d want 3", lat); end
    vectors++; if (res_b[0] !== 8'sd56 || res_b[1] !== 8'sd48) begin miscompares++; $display("FAIL lanes_p2_result: got %0d,%0d want 56,48", res_b[0], res_b[1]); end
    tick();
    wc[0][0] = 16'sd1024;  wc[0][1] = 16'sd1024;
    wc[1][0] = 16'sd2048;  wc[1][1] = -16'sd1024;
    wc[2][0] = -16'sd1024; wc[2][1] = 16'sd0;
    bc[0] = 8'sd8; bc[1] = 8'sd0; bc[2] = 8'sd4;
    run_c(lat);
    vectors++; if (lat !== 6) begin miscompares++; $display("FAIL lanes_no3_latency: got %0d want 6", lat); end
    vectors++; if (res_c[0] !== 8'sd56 || res_c[1] !== 8'sd48) begin miscompares++; $display("FAIL lanes_no3_r01: got %0d,%0d want 56,48", res_c[0], res_c[1]); end
    vectors++; if (res_c[2] !== -8'sd28) begin miscompares++; $display("FAIL lanes_no3_r2: got %0d want -28", res_c[2]); end
    vectors++; if (sat_c !== 1'b0) begin miscompares++; $display("FAIL lanes_no3_sat: got %b want 0", sat_c); end
    tick();
    vectors++; if (ir_c !== 1'b1) begin miscompares++; $display("FAIL lanes_no3_handoff: got %b want 1", ir_c); end
  endtask

  task automatic test_saturation;
    int lat;
    logic signed [7:0] e1;
    e1 = RELU ? 8'sh00 : 8'sh80;
    xin[0] = 8'sd96; xin[1] = 8'sd96;
    wa[0][0] = 16'sd2048;  wa[0][1] = 16'sd2048;
    wa[1][0] = -16'sd2048; wa[1][1] = -16'sd2048;
    ba[0] = 8'sd0; ba[1] = 8'sd0;
    run_a(lat);
    vectors++; if (res_a[0] !== 8'sd127) begin miscompares++; $display("FAIL sat_r0: got %0d want 127", res_a[0]); end
    vectors++; if (res_a[1] !== e1) begin miscompares++; $display("FAIL sat_r1: got %0d want %0d", res_a[1], e1); end
    vectors++; if (sat_a !== 1'b1) begin miscompares++; $display("FAIL sat_flag: got %b want 1", sat_a); end
    tick();
  endtask

  task automatic test_truncation;
    int lat;
    logic signed [7:0] e0;
    e0 = RELU ? 8'sh00 : 8'shFF;
    xin[0] = -8'sd1; xin[1] = 8'sd0;
    wa[0][0] = 16'sd512; wa[0][1] = 16'sd0;
    wa[1][0] = 16'sd0;   wa[1][1] = 16'sd0;
    ba[0] = 8'sd0; ba[1] = 8'sd0;
    run_a(lat);
    vectors++; if (res_a[0] !== e0) begin miscompares++; $display("FAIL trunc_r0: got %0d want %0d", res_a[0], e0); end
    vectors++; if (res_a[1] !== 8'sd0) begin miscompares++; $display("FAIL trunc_r1: got %0d want 0", res_a[1]); end
    vectors++; if (sat_a !== 1'b0) begin miscompares++; $display("FAIL trunc_sat_cleared: got %b want 0", sat_a); end
    tick();
  endtask

  task automatic test_backpressure;
    int lat;
    set_basic();
    or_a = 1'b0;
    run_a(lat);
    vectors++; if (lat !== 6) begin miscompares++; $display("FAIL bp_latency: got %0d want 6", lat); end
    for (int k = 0; k < 10; k++) begin
      iv_a = k[0];
      xin[0] = 8'sd100; xin[1] = -8'sd100;
      tick();
      vectors++; if (ov_a !== 1'b1 || ir_a !== 1'b0) begin miscompares++; $display("FAIL bp_hold_hs cycle %0d: got ov=%b ir=%b want ov=1 ir=0", k, ov_a, ir_a); end
      vectors++; if (res_a[0] !== 8'sd56 || res_a[1] !== 8'sd48 || sat_a !== 1'b0) begin miscompares++; $display("FAIL bp_hold_data cycle %0d: got %0d,%0d sat=%b want 56,48 sat=0", k, res_a[0], res_a[1], sat_a); end
    end
    iv_a = 1'b0;
    set_basic();
    or_a = 1'b1;
    tick();
    vectors++; if (ov_a !== 1'b0 || ir_a !== 1'b1) begin miscompares++; $display("FAIL bp_release: got ov=%b ir=%b want ov=0 ir=1", ov_a, ir_a); end
  endtask

  task automatic test_reset_mid_mac;
    int lat;
    set_basic();
    iv_a = 1'b1;
    tick();
    iv_a = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    vectors++; if (ov_a !== 1'b0 || ir_a !== 1'b0) begin miscompares++; $display("FAIL midrst_hs: got ov=%b ir=%b want ov=0 ir=0", ov_a, ir_a); end
    vectors++; if (res_a[0] !== 8'sd0 || res_a[1] !== 8'sd0) begin miscompares++; $display("FAIL midrst_result: got %0d,%0d want 0,0", res_a[0], res_a[1]); end
    rst = 1'b0;
    #1;
    vectors++; if (ir_a !== 1'b1) begin miscompares++; $display("FAIL midrst_ready: got %b want 1", ir_a); end
    run_a(lat);
    vectors++; if (lat !== 6) begin miscompares++; $display("FAIL midrst_latency: got %0d want 6", lat); end
    vectors++; if (res_a[0] !== 8'sd56 || res_a[1] !== 8'sd48) begin miscompares++; $display("FAIL midrst_result_after: got %0d,%0d want 56,48", res_a[0], res_a[1]); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lane_scaling();
    test_saturation();
    test_truncation();
    test_backpressure();
    test_reset_mid_mac();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
